pipe_skid_stage: RTL and testbench

- Parametrised successor to the fixed-field EXE/MEM pipeline latch.
- Replaces the global stall-vector scheme with a local valid/ready handshake, an optional 2-entry skid buffer and a synchronous flush.
- Carries an opaque payload of DATA_W bits between any two pipeline stages (IF/ID, ID/EXE, EXE/MEM, MEM/WB).
- Any cycle without a valid output presents a zeroed NOP payload.

---
 rtl/pipe_skid_stage.sv | 123 ++++++++++++
 tb/tb_pipe_skid_stage.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/pipe_skid_stage.sv
`default_nettype none
// ============================================================================
// Module   : pipe_skid_stage
// Brief    : Valid/ready pipeline stage with optional 2-entry skid buffer,
//            synchronous flush and NOP payload on bubbles.
// Revision : 1.0
// ============================================================================
module pipe_skid_stage #(
    parameter int                DATA_W      = 71,
    parameter int                SKID        = 1,
    parameter logic [DATA_W-1:0] NOP_PAYLOAD = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        occupancy
);

    logic              r_main_valid;
    logic [DATA_W-1:0] r_main_data;
    logic              w_in_fire;
    logic              w_out_fire;

    assign w_in_fire  = in_valid & in_ready;
    assign w_out_fire = r_main_valid & out_ready;

    // Bubbles present the NOP payload so downstream never sees stale fields.
    assign out_valid = r_main_valid;
    assign out_data  = r_main_valid ? r_main_data : NOP_PAYLOAD;

    if (SKID != 0) begin : g_skid
        logic              r_skid_valid;
        logic [DATA_W-1:0] r_skid_data;
        logic [1:0]        r_occupancy;
        logic              w_main_valid_nxt;
        logic              w_skid_valid_nxt;
        logic              w_load_main_in;
        logic              w_load_main_skid;
        logic              w_load_skid;

        // Depends on flops only, breaking the out_ready -> in_ready path.
        assign in_ready  = ~r_skid_valid;
        assign occupancy = r_occupancy;

        always_comb begin
            w_main_valid_nxt = r_main_valid;
            w_skid_valid_nxt = r_skid_valid;
            w_load_main_in   = 1'b0;
            w_load_main_skid = 1'b0;
            w_load_skid      = 1'b0;
            if (flush) begin
                w_main_valid_nxt = 1'b0;
                w_skid_valid_nxt = 1'b0;
            end else if (!r_main_valid) begin
                if (w_in_fire) begin
                    w_main_valid_nxt = 1'b1;
                    w_load_main_in   = 1'b1;
                end
            end else if (r_skid_valid) begin
                if (w_out_fire) begin
                    w_load_main_skid = 1'b1;
                    w_skid_valid_nxt = 1'b0;
                end
            end else if (w_out_fire) begin
                if (w_in_fire) begin
                    w_load_main_in = 1'b1;
                end else begin
                    w_main_valid_nxt = 1'b0;
                end
            end else if (w_in_fire) begin
                w_load_skid      = 1'b1;
                w_skid_valid_nxt = 1'b1;
            end
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                r_main_valid <= 1'b0;
                r_skid_valid <= 1'b0;
                r_main_data  <= NOP_PAYLOAD;
                r_skid_data  <= NOP_PAYLOAD;
                r_occupancy  <= 2'd0;
            end else begin
                r_main_valid <= w_main_valid_nxt;
                r_skid_valid <= w_skid_valid_nxt;
                r_occupancy  <= {1'b0, w_main_valid_nxt} + {1'b0, w_skid_valid_nxt};
                if (w_load_main_in) begin
                    r_main_data <= in_data;
                end else if (w_load_main_skid) begin
                    r_main_data <= r_skid_data;
                end
                if (w_load_skid) begin
                    r_skid_data <= in_data;
                end
            end
        end
    end else begin : g_no_skid
        assign in_ready  = ~r_main_valid | out_ready;
        assign occupancy = {1'b0, r_main_valid};

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                r_main_valid <= 1'b0;
                r_main_data  <= NOP_PAYLOAD;
            end else if (flush) begin
                r_main_valid <= 1'b0;
            end else if (w_in_fire) begin
                r_main_valid <= 1'b1;
                r_main_data  <= in_data;
            end else if (w_out_fire) begin
                r_main_valid <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_pipe_skid_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_pipe_skid_stage
// Brief    : Self-checking bench driving SKID=1 and SKID=0 stages in parallel
//            against queue-based reference models.
// Revision : 1.0
// ============================================================================
module tb_pipe_skid_stage;

    localparam int          c_dw  = 8;
    localparam logic [7:0]  c_nop = 8'h00;

    logic            clk;
    logic            rst;
    logic            flush;
    logic            in_valid;
    logic [c_dw-1:0] in_data;
    logic            out_ready;

    logic            rdy1, ov1, rdy0, ov0;
    logic [c_dw-1:0] od1, od0;
    logic [1:0]      occ1, occ0;

    int n_checks = 0;
    int n_errors = 0;

    // Reference models: each stage is a FIFO of capacity 2 (skid) or 1 (no skid).
    logic [c_dw-1:0] q1[$];
    logic [c_dw-1:0] q0[$];

    pipe_skid_stage #(.DATA_W(c_dw), .SKID(1), .NOP_PAYLOAD(c_nop)) u_skid (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(rdy1), .in_data(in_data),
        .out_valid(ov1), .out_ready(out_ready), .out_data(od1),
        .occupancy(occ1)
    );

    pipe_skid_stage #(.DATA_W(c_dw), .SKID(0), .NOP_PAYLOAD(c_nop)) u_noskid (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(rdy0), .in_data(in_data),
        .out_valid(ov0), .out_ready(out_ready), .out_data(od0),
        .occupancy(occ0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_models();
        check_eq("skid.out_valid", 32'(ov1), 32'(q1.size() > 0));
        check_eq("skid.out_data", 32'(od1), (q1.size() > 0) ? 32'(q1[0]) : 32'(c_nop));
        check_eq("skid.occupancy", 32'(occ1), 32'(q1.size()));
        check_eq("skid.in_ready", 32'(rdy1), 32'(q1.size() < 2));
        check_eq("noskid.out_valid", 32'(ov0), 32'(q0.size() > 0));
        check_eq("noskid.out_data", 32'(od0), (q0.size() > 0) ? 32'(q0[0]) : 32'(c_nop));
        check_eq("noskid.occupancy", 32'(occ0), 32'(q0.size()));
        check_eq("noskid.in_ready", 32'(rdy0), 32'((q0.size() == 0) || out_ready));
    endtask

    // Called just after a rising edge: drive, check mid-cycle, then advance models at the edge.
    task automatic cycle(input logic iv, input logic [c_dw-1:0] id, input logic ordy, input logic fl);
        bit f1, f0, o1, o0;
        in_valid  = iv;
        in_data   = id;
        out_ready = ordy;
        flush     = fl;
        @(negedge clk);
        check_models();
        f1 = iv && (q1.size() < 2);
        f0 = iv && ((q0.size() == 0) || ordy);
        o1 = ordy && (q1.size() > 0);
        o0 = ordy && (q0.size() > 0);
        @(posedge clk);
        if (fl) begin
            q1.delete();
            q0.delete();
        end else begin
            if (o1) void'(q1.pop_front());
            if (f1) q1.push_back(id);
            if (o0) void'(q0.pop_front());
            if (f0) q0.push_back(id);
        end
        #1;
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst.out_valid", 32'(ov1 | ov0), 32'd0);
        check_eq("rst.out_data", 32'({od1, od0}), 32'd0);
        check_eq("rst.occupancy", 32'({occ1, occ0}), 32'd0);
        check_eq("rst.in_ready", 32'({rdy1, rdy0}), 32'd3);
        @(negedge clk) rst = 1'b0;
        @(posedge clk); #1;

        // Streaming with out_ready held high
        cycle(1'b1, 8'h11, 1'b1, 1'b0);
        check_eq("stream.first", 32'(od1), 32'h11);
        cycle(1'b1, 8'h22, 1'b1, 1'b0);
        check_eq("stream.second", 32'(od1), 32'h22);
        cycle(1'b1, 8'h33, 1'b1, 1'b0);
        check_eq("stream.third", 32'(od0), 32'h33);
        check_eq("stream.ready", 32'(rdy1), 32'd1);
        cycle(1'b0, 8'h00, 1'b1, 1'b0);

        // Back-pressure fills the skid buffer
        cycle(1'b1, 8'hA1, 1'b0, 1'b0);
        cycle(1'b1, 8'hB2, 1'b0, 1'b0);
        check_eq("fill.occ", 32'(occ1), 32'd2);
        check_eq("fill.ready", 32'(rdy1), 32'd0);
        check_eq("fill.noskid_ready", 32'(rdy0), 32'd0);
        check_eq("fill.noskid_data", 32'(od0), 32'hA1);
        cycle(1'b0, 8'h00, 1'b1, 1'b0);
        check_eq("drain.second", 32'(od1), 32'hB2);
        check_eq("drain.ready", 32'(rdy1), 32'd1);
        cycle(1'b0, 8'h00, 1'b1, 1'b0);
        cycle(1'b0, 8'h00, 1'b1, 1'b0);

        // Flush with a full skid and a concurrent input
        cycle(1'b1, 8'hA1, 1'b0, 1'b0);
        cycle(1'b1, 8'hB2, 1'b0, 1'b0);
        cycle(1'b1, 8'hC3, 1'b0, 1'b1);
        check_eq("flush.valid", 32'(ov1), 32'd0);
        check_eq("flush.occ", 32'(occ1), 32'd0);
        check_eq("flush.data", 32'(od1), 32'(c_nop));
        check_eq("flush.ready", 32'(rdy1), 32'd1);
        cycle(1'b0, 8'h00, 1'b1, 1'b0);
        cycle(1'b0, 8'h00, 1'b1, 1'b0);

        // Simultaneous pass-through on the single-register stage
        cycle(1'b1, 8'h44, 1'b0, 1'b0);
        cycle(1'b1, 8'h55, 1'b1, 1'b0);
        check_eq("pass.data", 32'(od0), 32'h55);
        check_eq("pass.occ", 32'(occ0), 32'd1);
        cycle(1'b0, 8'h00, 1'b1, 1'b0);
        cycle(1'b0, 8'h00, 1'b1, 1'b0);

        // Asynchronous reset with payload held
        cycle(1'b1, 8'h66, 1'b0, 1'b0);
        in_valid = 1'b0; out_ready = 1'b0;
        #2 rst = 1'b1;
        #1;
        check_eq("arst.out_valid", 32'({ov1, ov0}), 32'd0);
        check_eq("arst.out_data", 32'({od1, od0}), 32'd0);
        check_eq("arst.occupancy", 32'({occ1, occ0}), 32'd0);
        q1.delete();
        q0.delete();
        @(negedge clk) rst = 1'b0;
        @(posedge clk); #1;

        // Randomised traffic on both variants
        for (int i = 0; i < 10000; i++) begin
            cycle(1'($urandom_range(0, 3) != 0),
                  8'($urandom_range(0, 255)),
                  1'($urandom_range(0, 2) != 0),
                  1'($urandom_range(0, 63) == 0));
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
